// File: rtl/bal_pkg.sv
// Shared types, constants and saturation helpers
// for the second-generation balance controller.
package bal_pkg;

    typedef enum logic [1:0] {
        OFF        = 2'd0,
        SOFT_START = 2'd1,
        RUN        = 2'd2,
        DECAY      = 2'd3
    } state_t;

    localparam int POT_MIN = 'h200;
    localparam int POT_MAX = 'hE00;
    localparam int POT_MID = 'h7FF;
    localparam int STEER_MUL = 3;
    localparam int STEER_SHIFT = 4;

    localparam int P_GAIN = 5;
    localparam int I_SHIFT = 6;
    localparam int D_SHIFT = 6;

    localparam int ERR_MIN = -512;
    localparam int ERR_MAX = 511;
    localparam int D_MIN = -2048;
    localparam int D_MAX = 2047;

    localparam int SS_SHIFT = 8;

    function automatic int clamp(
        input int v,
        input int lo,
        input int hi
    );
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Saturate to the range of a w-bit two's complement value.
    function automatic int sat(
        input int v,
        input int w
    );
        int hi;
        hi = (1 <<< (w - 1)) - 1;
        return clamp(v, -hi - 1, hi);
    endfunction

endpackage

// File: rtl/bal_slew.sv
// Per-wheel slew limiter: on each vld the output
// moves toward tgt by at most SLEW_MAX.
module bal_slew
    import bal_pkg::*;
#(
    parameter int SW       = 12,
    parameter int SLEW_MAX = 64
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 vld,
    input  logic signed [SW-1:0] tgt,
    output logic signed [SW-1:0] out
);

    int                 diff;
    logic signed [SW-1:0] nxt;

    always_comb begin
        diff = int'(tgt) - int'(out);
        nxt  = tgt;
        if (diff > SLEW_MAX)
            nxt = out + SW'(SLEW_MAX);
        else if (diff < -SLEW_MAX)
            nxt = out - SW'(SLEW_MAX);
    end

    always_ff @(posedge clk) begin
        if (clr)
            out <= '0;
        else if (vld)
            out <= nxt;
    end

endmodule

// File: rtl/balance_cntrl_gen2.sv
// Balance controller: PID pitch loop, soft start, steering
// mix, slew limiting and overspeed detect under one FSM.
module balance_cntrl_gen2
    import bal_pkg::*;
#(
    parameter int FAST_SIM     = 1,
    parameter int PW           = 16,
    parameter int SW           = 12,
    parameter int IW           = 18,
    parameter int SLEW_MAX     = 64,
    parameter int TOO_FAST_ON  = 1536,
    parameter int TOO_FAST_OFF = 1400
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vld,
    input  logic                 pwr_up,
    input  logic                 rider_off,
    input  logic                 en_steer,
    input  logic signed [PW-1:0] ptch,
    input  logic signed [PW-1:0] ptch_rt,
    input  logic        [11:0]   steer_pot,
    output logic signed [SW-1:0] lft_spd,
    output logic signed [SW-1:0] rght_spd,
    output logic                 too_fast,
    output logic        [1:0]    state
);

    state_t               fsm;
    logic signed [IW-1:0] integ;
    logic        [7:0]    ss_tmr;
    logic        [7:0]    ss_nxt;
    logic        [7:0]    pre;
    logic                 ss_tick;
    logic                 clr;
    logic                 step;
    logic                 tf_set;
    logic                 tf_clr;
    logic signed [SW-1:0] tgt_l;
    logic signed [SW-1:0] tgt_r;

    int err;
    int d_term;
    int pid;
    int pid_ss;
    int steer;
    int tl;
    int tr;
    int integ_nxt;
    int abs_l;
    int abs_r;

    assign state = fsm;

    // Power loss and reset both force the wheels to zero.
    assign clr  = rst || !pwr_up;
    assign step = vld && (fsm != OFF);

    assign ss_tick = (FAST_SIM != 0) || (pre == 8'hFF);
    assign ss_nxt  = (ss_tick && ss_tmr != 8'hFF)
                   ? ss_tmr + 8'd1 : ss_tmr;

    always_comb begin
        err    = clamp(int'(ptch), ERR_MIN, ERR_MAX);
        d_term = clamp(-(int'(ptch_rt) >>> D_SHIFT),
                       D_MIN, D_MAX);
        pid    = sat(err * P_GAIN
                     + (int'(integ) >>> I_SHIFT)
                     + d_term, SW);
        pid_ss = (pid * int'(ss_tmr)) >>> SS_SHIFT;
        steer  = ((clamp(int'(steer_pot), POT_MIN, POT_MAX)
                   - POT_MID) * STEER_MUL) >>> STEER_SHIFT;
        tl = pid_ss;
        tr = pid_ss;
        if (en_steer) begin
            tl = sat(pid_ss + steer, SW);
            tr = sat(pid_ss - steer, SW);
        end
        if (fsm == DECAY) begin
            tl = 0;
            tr = 0;
        end
        integ_nxt = sat(int'(integ) + err, IW);
    end

    assign tgt_l = SW'(tl);
    assign tgt_r = SW'(tr);

    always_comb begin
        abs_l  = (lft_spd < 0) ? -int'(lft_spd) : int'(lft_spd);
        abs_r  = (rght_spd < 0) ? -int'(rght_spd) : int'(rght_spd);
        tf_set = (abs_l > TOO_FAST_ON) || (abs_r > TOO_FAST_ON);
        tf_clr = (abs_l < TOO_FAST_OFF) && (abs_r < TOO_FAST_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst || !pwr_up) begin
            fsm      <= OFF;
            integ    <= '0;
            ss_tmr   <= '0;
            pre      <= '0;
            too_fast <= 1'b0;
        end else begin
            if (tf_set)
                too_fast <= 1'b1;
            else if (tf_clr)
                too_fast <= 1'b0;

            unique case (fsm)
                OFF: begin
                    if (!rider_off) begin
                        fsm    <= SOFT_START;
                        ss_tmr <= '0;
                        pre    <= '0;
                    end
                end
                SOFT_START, RUN: begin
                    if (vld)
                        integ <= IW'(integ_nxt);
                    if (fsm == SOFT_START) begin
                        ss_tmr <= ss_nxt;
                        pre    <= pre + 8'd1;
                    end
                    // The slew step this edge still uses the old target.
                    if (rider_off) begin
                        fsm   <= DECAY;
                        integ <= '0;
                    end else if (fsm == SOFT_START
                                 && ss_nxt == 8'hFF) begin
                        fsm <= RUN;
                    end
                end
                DECAY: begin
                    if (!rider_off && lft_spd == '0
                        && rght_spd == '0) begin
                        fsm    <= SOFT_START;
                        ss_tmr <= '0;
                        pre    <= '0;
                    end
                end
            endcase
        end
    end

    bal_slew #(
        .SW       (SW),
        .SLEW_MAX (SLEW_MAX)
    ) u_slew_l (
        .clk (clk),
        .clr (clr),
        .vld (step),
        .tgt (tgt_l),
        .out (lft_spd)
    );

    bal_slew #(
        .SW       (SW),
        .SLEW_MAX (SLEW_MAX)
    ) u_slew_r (
        .clk (clk),
        .clr (clr),
        .vld (step),
        .tgt (tgt_r),
        .out (rght_spd)
    );

endmodule

// File: tb/tb_balance_cntrl_gen2.sv
// Bench for balance_cntrl_gen2: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_balance_cntrl_gen2;

    logic               clk = 1'b0;
    logic               rst;
    logic               vld;
    logic               pwr_up;
    logic               rider_off;
    logic               en_steer;
    logic signed [15:0] ptch;
    logic signed [15:0] ptch_rt;
    logic        [11:0] steer_pot;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               too_fast;
    logic        [1:0]  state;

    int total = 0;
    int bad   = 0;

    int m_st, m_l, m_r, m_tf, m_int, m_ss;

    balance_cntrl_gen2 #(.FAST_SIM(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .vld       (vld),
        .pwr_up    (pwr_up),
        .rider_off (rider_off),
        .en_steer  (en_steer),
        .ptch      (ptch),
        .ptch_rt   (ptch_rt),
        .steer_pot (steer_pot),
        .lft_spd   (lft_spd),
        .rght_spd  (rght_spd),
        .too_fast  (too_fast),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic int clampi(int v, int lo, int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic int absi(int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int target(bit left);
        int e, pid, pidss, st;
        if (m_st == 3) return 0;
        e = clampi(int'(ptch), -512, 511);
        pid = clampi(5 * e + (m_int >>> 6)
                     + clampi(-(int'(ptch_rt) >>> 6), -2048, 2047),
                     -2048, 2047);
        pidss = (pid * m_ss) >>> 8;
        if (!en_steer) return pidss;
        st = ((clampi(int'(steer_pot), 512, 3584) - 2047) * 3) >>> 4;
        return clampi(left ? pidss + st : pidss - st, -2048, 2047);
    endfunction

    function automatic int slew(int o, int t);
        if (t > o) return o + ((t - o) < 64 ? (t - o) : 64);
        return o - ((o - t) < 64 ? (o - t) : 64);
    endfunction

    // Advance model and DUT by one clock; inputs are sampled as set now.
    task automatic tick();
        int nst, nl, nr, ntf, nint, nss;
        nst = m_st; nl = m_l; nr = m_r;
        ntf = m_tf; nint = m_int; nss = m_ss;
        if (rst || !pwr_up) begin
            nst = 0; nl = 0; nr = 0; ntf = 0; nint = 0; nss = 0;
        end else begin
            if (absi(m_l) > 1536 || absi(m_r) > 1536) ntf = 1;
            else if (absi(m_l) < 1400 && absi(m_r) < 1400) ntf = 0;
            if (vld && m_st != 0) begin
                nl = slew(m_l, target(1));
                nr = slew(m_r, target(0));
            end
            case (m_st)
                0: if (!rider_off) begin nst = 1; nss = 0; end
                1, 2: begin
                    if (vld)
                        nint = clampi(m_int + clampi(int'(ptch), -512, 511),
                                      -131072, 131071);
                    if (m_st == 1) nss = (m_ss < 255) ? m_ss + 1 : 255;
                    if (rider_off) begin nst = 3; nint = 0; end
                    else if (m_st == 1 && nss == 255) nst = 2;
                end
                default: if (!rider_off && m_l == 0 && m_r == 0) begin
                    nst = 1; nss = 0;
                end
            endcase
        end
        @(posedge clk);
        #1;
        m_st = nst; m_l = nl; m_r = nr;
        m_tf = ntf; m_int = nint; m_ss = nss;
    endtask

    task automatic pulse();
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic run_until_run(output int n);
        n = 0;
        while (state != 2'd2 && n < 400) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pwr_up = 1'b1; rider_off = 1'b0; vld = 1'b0;
        en_steer = 1'b0; ptch = '0; ptch_rt = '0; steer_pot = 12'h800;
        tick();
        tick();
        total++;
        if ({state, lft_spd, rght_spd, too_fast} !== 27'd0) begin
            bad++;
            $display("FAIL reset st=%0d l=%0d r=%0d tf=%0b want all 0",
                     state, lft_spd, rght_spd, too_fast);
        end
    endtask

    task automatic test_startup();
        int n;
        rst = 1'b0;
        tick();
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL startup_enter st=%0d want 1", state);
        end
        run_until_run(n);
        total++;
        if (n !== 255) begin
            bad++; $display("FAIL startup_len clks=%0d want 255", n);
        end
        total++;
        if ({lft_spd, rght_spd, too_fast} !== 25'd0) begin
            bad++;
            $display("FAIL startup_out l=%0d r=%0d tf=%0b want 0",
                     lft_spd, rght_spd, too_fast);
        end
    endtask

    task automatic test_pid();
        int exp_s[8] = '{64, 128, 192, 256, 320, 384, 448, 508};
        en_steer = 1'b0; ptch = 16'sd100; ptch_rt = '0;
        for (int k = 0; k < 8; k++) begin
            pulse();
            total++;
            if (lft_spd !== 12'(exp_s[k]) || rght_spd !== 12'(exp_s[k])) begin
                bad++;
                $display("FAIL pid_step%0d l=%0d r=%0d want %0d",
                         k, lft_spd, rght_spd, exp_s[k]);
            end
            tick();
            total++;
            if (lft_spd !== 12'(exp_s[k])) begin
                bad++;
                $display("FAIL pid_hold%0d l=%0d want %0d",
                         k, lft_spd, exp_s[k]);
            end
        end
    endtask

    task automatic test_rider_off();
        int n;
        int exp_s[8] = '{444, 380, 316, 252, 188, 124, 60, 0};
        rider_off = 1'b1;
        tick();
        total++;
        if (state !== 2'd3) begin
            bad++; $display("FAIL decay_enter st=%0d want 3", state);
        end
        for (int k = 0; k < 8; k++) begin
            pulse();
            total++;
            if (lft_spd !== 12'(exp_s[k]) || rght_spd !== 12'(exp_s[k])) begin
                bad++;
                $display("FAIL decay_step%0d l=%0d r=%0d want %0d",
                         k, lft_spd, rght_spd, exp_s[k]);
            end
        end
        rider_off = 1'b0;
        tick();
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL decay_exit st=%0d want 1", state);
        end
        run_until_run(n);
        total++;
        if (n !== 255) begin
            bad++; $display("FAIL restart_len clks=%0d want 255", n);
        end
    endtask

    task automatic test_steer();
        int exp_s[5] = '{64, 128, 192, 256, 288};
        ptch = '0; en_steer = 1'b1; steer_pot = 12'hFFF;
        for (int k = 0; k < 5; k++) begin
            pulse();
            total++;
            if (lft_spd !== 12'(exp_s[k]) || rght_spd !== 12'(-exp_s[k])) begin
                bad++;
                $display("FAIL steer_step%0d l=%0d r=%0d want %0d/-%0d",
                         k, lft_spd, rght_spd, exp_s[k], exp_s[k]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int n;
        rst = 1'b1;
        tick();
        total++;
        if ({state, lft_spd, rght_spd, too_fast} !== 27'd0) begin
            bad++;
            $display("FAIL midrst st=%0d l=%0d r=%0d tf=%0b want all 0",
                     state, lft_spd, rght_spd, too_fast);
        end
        rst = 1'b0;
        tick();
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL midrst_exit st=%0d want 1", state);
        end
        run_until_run(n);
        total++;
        if (n !== 255) begin
            bad++; $display("FAIL midrst_len clks=%0d want 255", n);
        end
    endtask

    task automatic climb();
        en_steer = 1'b0; ptch = 16'sd511; ptch_rt = '0;
        for (int k = 1; k <= 25; k++) begin
            pulse();
            total++;
            if (lft_spd !== 12'(64 * k) || rght_spd !== 12'(64 * k)
                || too_fast !== 1'b0) begin
                bad++;
                $display("FAIL climb%0d l=%0d r=%0d tf=%0b want %0d tf=0",
                         k, lft_spd, rght_spd, too_fast, 64 * k);
            end
        end
        tick();
        total++;
        if (too_fast !== 1'b1) begin
            bad++; $display("FAIL too_fast_set tf=%0b want 1", too_fast);
        end
    endtask

    task automatic test_overspeed();
        climb();
        pwr_up = 1'b0;
        tick();
        total++;
        if ({state, lft_spd, rght_spd, too_fast} !== 27'd0) begin
            bad++;
            $display("FAIL pwr_down st=%0d l=%0d r=%0d tf=%0b want all 0",
                     state, lft_spd, rght_spd, too_fast);
        end
        pwr_up = 1'b1;
        tick();
        total++;
        if (state !== 2'd1) begin
            bad++; $display("FAIL pwr_up_again st=%0d want 1", state);
        end
    endtask

    task automatic test_hysteresis();
        int n;
        run_until_run(n);
        total++;
        if (n !== 255) begin
            bad++; $display("FAIL hyst_len clks=%0d want 255", n);
        end
        climb();
        ptch = '0;
        for (int k = 1; k <= 4; k++) pulse();
        total++;
        if (lft_spd !== 12'sd1344 || too_fast !== 1'b1) begin
            bad++;
            $display("FAIL hyst_hold l=%0d tf=%0b want 1344 tf=1",
                     lft_spd, too_fast);
        end
        tick();
        total++;
        if (too_fast !== 1'b0) begin
            bad++; $display("FAIL hyst_clear tf=%0b want 0", too_fast);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            pwr_up = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 199) == 0) rider_off = ~rider_off;
            vld = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 31) == 0) ptch = 16'($urandom);
            else ptch = 16'(int'($urandom_range(0, 1200)) - 500);
            ptch_rt = 16'($urandom);
            steer_pot = 12'($urandom);
            en_steer = 1'($urandom_range(0, 1));
            tick();
            total++;
            if ({state, lft_spd, rght_spd, too_fast}
                !== {2'(m_st), 12'(m_l), 12'(m_r), 1'(m_tf)}) begin
                bad++;
                if (bad < 20)
                    $display("FAIL rand%0d st=%0d l=%0d r=%0d tf=%0b want %0d %0d %0d %0d",
                             i, state, lft_spd, rght_spd, too_fast,
                             m_st, m_l, m_r, m_tf);
            end
        end
        vld = 1'b0;
    endtask

    initial begin
        m_st = 0; m_l = 0; m_r = 0; m_tf = 0; m_int = 0; m_ss = 0;
        test_reset();
        test_startup();
        test_pid();
        test_rider_off();
        test_steer();
        test_reset_midop();
        test_overspeed();
        test_hysteresis();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/balance_cntrl_gen2.md
Name: balance_cntrl_gen2

Overview:
Parametrised second-generation Segway balance controller. It fuses the PID pitch loop, soft-start scaling, steering mix, per-wheel slew limiting and a too-fast detector with hysteresis behind one explicit power/rider state machine. It sits between the inertial interface (ptch, ptch_rt, vld) and the motor drive (lft_spd, rght_spd).

Parameters:
FAST_SIM, 1, 1: ss_tmr advances every clk; 0: every 256 clks
PW, 16, width of ptch/ptch_rt (signed)
SW, 12, width of lft_spd/rght_spd (signed)
IW, 18, integrator width (signed)
SLEW_MAX, 64, max per-vld change of each wheel speed
TOO_FAST_ON, 1536, too_fast asserts when |speed| exceeds this
TOO_FAST_OFF, 1400, too_fast clears when both |speed| are below this

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
vld  in  1  new ptch/ptch_rt sample, single-cycle pulse
pwr_up  in  1  power enable (level)
rider_off  in  1  rider absent (level)
en_steer  in  1  steering enable
ptch  in  PW  signed pitch
ptch_rt  in  PW  signed pitch rate
steer_pot  in  12  unsigned steering pot
lft_spd  out  SW  signed left wheel command, registered
rght_spd  out  SW  signed right wheel command, registered
too_fast  out  1  overspeed flag, registered
state  out  2  OFF=0, SOFT_START=1, RUN=2, DECAY=3

Behaviour:
- Reset (rst=1 at clk edge): state=OFF; lft_spd=rght_spd=0; too_fast=0; integrator=0; ss_tmr=0. Reset mid-operation has the same effect on the next edge.
- err = clamp(ptch, -512, 511). P = err*5.
- I = integrator >>> 6.
- D = clamp(-(ptch_rt >>> 6), -2048, 2047).
- PID = clamp(P+I+D) to SW bits signed.
- Integrator: on vld in SOFT_START/RUN, integrator += sext(err), saturating at IW-bit signed limits. The target uses the pre-update integrator value. The integrator is cleared in OFF and on entry to DECAY.
- ss_tmr: 8-bit. Advances only in SOFT_START (rate per FAST_SIM) and saturates at 255. Cleared in OFF and on DECAY→SOFT_START.
- PID_ss = (PID*ss_tmr) >>> 8, computed as a signed product.
- Steer:
  - pot = clamp(steer_pot, 0x200, 0xE00); st = ((pot-0x7FF)*3) >>> 4, signed.
  - en_steer=1: tgtL = PID_ss+st, tgtR = PID_ss-st. en_steer=0: both equal PID_ss.
  - Both targets are saturated to SW bits.
- DECAY: tgtL = tgtR = 0.
- Slew: on vld in SOFT_START/RUN/DECAY, each output moves toward its target by min(|tgt-out|, SLEW_MAX). Outputs hold between vlds. Latency is 1 clk from the vld edge.
- too_fast: registered from the registered speeds, so it lags the speeds by 1 clk.
  - Sets when |lft|>TOO_FAST_ON or |rght|>TOO_FAST_ON.
  - Clears when both are <TOO_FAST_OFF.
  - Otherwise holds.
- FSM:
  - Any state with pwr_up=0 → OFF next clk: outputs, too_fast, integrator and ss_tmr all 0. This has priority over every other transition.
  - OFF → SOFT_START when pwr_up=1 and rider_off=0 (level sensitive).
  - SOFT_START → RUN when ss_tmr==255.
  - SOFT_START/RUN → DECAY when rider_off=1.
  - DECAY → SOFT_START when rider_off=0 and lft_spd==0 and rght_spd==0. ss_tmr restarts from 0.
  - When rider_off and vld coincide in RUN: the slew step is taken toward the old target, and the state changes the same edge.

Decomposition:
- Package bal_pkg holds:
  - state_t enum (OFF, SOFT_START, RUN, DECAY)
  - constants: pot limits 0x200/0xE00, centre 0x7FF, P gain 5, I shift 6, D shift 6
  - a parametrised signed saturate function
- Sub-module bal_slew (per-wheel slew limiter: tgt, vld, clr, out), instantiated twice.

Test Plan:
- Startup: rst, then pwr_up=1, rider_off=0, ptch=ptch_rt=0, FAST_SIM=1 → state reaches RUN 255 clks after entering SOFT_START; speeds stay 0 and too_fast=0.
- Slew/PID: RUN, en_steer=0, ptch=100 held for 8 vlds → lft=rght=64,128,…,448, then 508 on the 8th vld.
- Steer: RUN, ptch=0, en_steer=1, steer_pot=0xFFF (clamped 0xE00, st=288), 5 vlds → lft 64,128,192,256,288 and rght the negatives of those values.
- Overspeed: RUN, ptch=511 → speeds step by 64; too_fast=1 one clk after speed=1600 (25th vld); dropping pwr_up → next clk state=OFF, speeds 0, too_fast 0.
- Rider off: RUN with lft=rght=508, rider_off=1 → DECAY, integrator 0, speeds 444,380,…,60,0 (8 vlds); rider_off=0 → SOFT_START with ss_tmr=0.
- Reset mid-op: rst=1 during RUN with nonzero speeds → next clk all outputs 0, state OFF; with pwr_up still 1 after rst falls → SOFT_START next clk.
